avalon_mm_csr: RTL

- Avalon-MM slave register file; consumes the slave side of the team's avalon_mm_if bus (address/write/writedata/read in; waitrequest/readdata/readdatavalid out).
- Decodes the extra address MSB into two banks: NUM_REGS read/write control registers that drive downstream datapath logic, and NUM_REGS read-only status registers sampled from the datapath.
- Sits between the bus master (testbench or host bridge) and the lab datapath.

---
 rtl/avalon_mm_csr.sv | 128 ++++++++++++
 1 files changed

// File: rtl/avalon_mm_csr.sv
// Avalon-MM slave register file: a bank of read/write control registers and a bank of
// read-only status registers, selected by the address MSB. Optional: AVALON_MM_CSR_BYTEEN_EN.
module avalon_mm_csr #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned NUM_REGS = 4,
  localparam int unsigned AWIDTH  = $clog2(NUM_REGS) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [AWIDTH-1:0]            amm_address_i,
  input  logic                         amm_write_i,
  input  logic [DWIDTH-1:0]            amm_writedata_i,
`ifdef AVALON_MM_CSR_BYTEEN_EN
  input  logic [DWIDTH/8-1:0]          amm_byteenable_i,
`endif
  input  logic                         amm_read_i,
  output logic                         amm_waitrequest_o,
  output logic [DWIDTH-1:0]            amm_readdata_o,
  output logic                         amm_readdatavalid_o,
  output logic [NUM_REGS*DWIDTH-1:0]   ctrl_o,
  output logic [NUM_REGS-1:0]          ctrl_wr_stb_o,
  input  logic [NUM_REGS*DWIDTH-1:0]   sts_i,
  output logic                         err_o
);

  localparam int unsigned NBytes = DWIDTH / 8;

  typedef enum logic [1:0] {StIdle, StAck, StResp} state_e;

  state_e state_q, state_d;

  logic [DWIDTH-1:0]   ctrl_q [NUM_REGS];
  logic [DWIDTH-1:0]   ctrl_d [NUM_REGS];
  logic [DWIDTH-1:0]   sts_arr [NUM_REGS];
  logic [NUM_REGS-1:0] stb_q, stb_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [NBytes-1:0]   be;
  logic [AWIDTH-2:0]   idx;
  logic                sts_bank;
  logic                ack;

`ifdef AVALON_MM_CSR_BYTEEN_EN
  assign be = amm_byteenable_i;
`else
  assign be = '1;
`endif

  assign idx      = amm_address_i[AWIDTH-2:0];
  assign sts_bank = amm_address_i[AWIDTH-1];
  assign ack      = (state_q == StAck);

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      sts_arr[k] = sts_i[k*DWIDTH +: DWIDTH];
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl_flat
    assign ctrl_o[k*DWIDTH +: DWIDTH] = ctrl_q[k];
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; write wins over a simultaneous read, so no RESP in that case
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (amm_read_i || amm_write_i) state_d = StAck;
      StAck:  state_d = (amm_read_i && !amm_write_i) ? StResp : StIdle;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    amm_waitrequest_o   = (state_q != StAck);
    amm_readdatavalid_o = (state_q == StResp);
  end

  // Register-file next state, all keyed off acceptance in ACK
  always_comb begin
    ctrl_d  = ctrl_q;
    stb_d   = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (ack && amm_write_i) begin
      if (sts_bank) begin
        err_d = 1'b1;
      end else begin
        for (int b = 0; b < NBytes; b++) begin
          if (be[b]) ctrl_d[idx][b*8 +: 8] = amm_writedata_i[b*8 +: 8];
        end
        stb_d[idx] = |be;
      end
      if (amm_read_i) err_d = 1'b1;
    end else if (ack && amm_read_i) begin
      rdata_d = sts_bank ? sts_arr[idx] : ctrl_q[idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_REGS; k++) ctrl_q[k] <= '0;
      stb_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      stb_q   <= stb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign amm_readdata_o = rdata_q;
  assign ctrl_wr_stb_o  = stb_q;
  assign err_o          = err_q;

endmodule
